// File: rtl/jtoutrun_cab_pkg.sv
// Shared definitions for the Out Run cabinet I/O block.
//   - register offsets within the I/O window (cpu_addr[5:1])
//   - ADC conversion state enum
//   - output latch bit positions
//   - adc_scale(): maps a raw signed analog sample to the 8-bit ADC code
package jtoutrun_cab_pkg;

  localparam logic [4:0] REG_SYS   = 5'h00;
  localparam logic [4:0] REG_JOY   = 5'h01;
  localparam logic [4:0] REG_DIPA  = 5'h02;
  localparam logic [4:0] REG_DIPB  = 5'h03;
  localparam logic [4:0] REG_LATCH = 5'h04;
  localparam logic [4:0] REG_ADC   = 5'h18;
  localparam logic [4:0] REG_WDOG  = 5'h1F;

  typedef enum logic [1:0] {ADC_IDLE, ADC_BUSY, ADC_DONE} adc_st_e;

  localparam int LB_FLIP  = 0;
  localparam int LB_MUTE  = 1;
  localparam int LB_COIN0 = 2;
  localparam int LB_COIN1 = 3;
  localparam int LB_VIDEO = 5;

  // ch0 is centred steering; ch1/ch2 are pedals where only the positive
  // half of the range is meaningful, so it is stretched to full scale.
  function automatic logic [7:0] adc_scale(input logic [1:0] ch, input logic [7:0] raw);
    logic [8:0] dbl;
    dbl = {raw, 1'b0};
    case (ch)
      2'd0:       adc_scale = raw + 8'h80;
      2'd1, 2'd2: adc_scale = raw[7] ? 8'h00 : (dbl[8] ? 8'hFF : dbl[7:0]);
      default:    adc_scale = 8'h80;
    endcase
  endfunction

endpackage

// File: rtl/jtoutrun_cab_if.sv
// Main CPU <-> cabinet I/O bus.
//   io_cs, RnW, LDSWn : chip select, read/not-write, low byte write strobe (low)
//   cpu_addr[12:1]    : word address, only [5:1] decoded by the cabinet
//   cpu_dout          : CPU write data, low byte
//   cab_dout          : cabinet read data
interface jtoutrun_cab_if;
  logic        io_cs;
  logic        RnW;
  logic        LDSWn;
  logic [12:1] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cab_dout;

  modport master (output io_cs, RnW, LDSWn, cpu_addr, cpu_dout, input cab_dout);
  modport slave  (input io_cs, RnW, LDSWn, cpu_addr, cpu_dout, output cab_dout);
endinterface

// File: rtl/jtoutrun_adc.sv
// ADC0804 emulation: conversion FSM, channel sample/hold and result register.
//   start  : one-cycle conversion request, ch selects the input (0..3)
//   steer/gas/brake : live signed analog samples
//   res    : last completed conversion; unchanged while a conversion runs
// A start always wins, including in BUSY where it discards the running
// conversion and reloads the counter.
module jtoutrun_adc
  import jtoutrun_cab_pkg::*;
#(
  parameter int ADC_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] ch,
  input  logic [7:0] steer,
  input  logic [7:0] gas,
  input  logic [7:0] brake,
  output logic [7:0] res
);
  localparam int CW = (ADC_CYCLES > 2) ? $clog2(ADC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ADC_CYCLES - 1);

  adc_st_e       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ch_q, ch_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    res_q, res_d;
  logic [7:0]    sample;

  always_comb begin
    case (ch)
      2'd0:    sample = steer;
      2'd1:    sample = gas;
      2'd2:    sample = brake;
      default: sample = 8'h00;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    ch_d   = ch_q;
    hold_d = hold_q;
    res_d  = res_q;
    if (start) begin
      st_d   = ADC_BUSY;
      cnt_d  = CNT_LOAD;
      ch_d   = ch;
      hold_d = sample;
    end else if (st_q == ADC_BUSY) begin
      if (cnt_q == '0) begin
        res_d = adc_scale(ch_q, hold_q);
        st_d  = ADC_DONE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ADC_IDLE;
      cnt_q  <= '0;
      ch_q   <= 2'd0;
      hold_q <= 8'h00;
      res_q  <= 8'h00;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      ch_q   <= ch_d;
      hold_q <= hold_d;
      res_q  <= res_d;
    end
  end

  assign res = res_q;
endmodule

// File: rtl/jtoutrun_cab.sv
// Out Run cabinet I/O: input ports, DIP readout, output latch, ADC and
// frame watchdog behind the main CPU I/O chip select.
//   bus        : CPU bus (slave side); cab_dout is combinational, zero latency
//   vint       : vertical interrupt, each rising edge is one frame
//   joystick1, joyana1, joyana1b, start_button, coin_input, service,
//   dip_test, dipsw_a/b : cabinet inputs
//   video_en, flip, snd_mute, coin_cnt : output latch bits
//   wdog_rst   : one-cycle pulse after WDOG_FRAMES frames without a kick
module jtoutrun_cab
  import jtoutrun_cab_pkg::*;
#(
  parameter int ADC_CYCLES  = 256,
  parameter int WDOG_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vint,
  jtoutrun_cab_if.slave bus,
  input  logic [7:0]  joystick1,
  input  logic [15:0] joyana1,
  input  logic [15:0] joyana1b,
  input  logic [1:0]  start_button,
  input  logic [1:0]  coin_input,
  input  logic        service,
  input  logic        dip_test,
  input  logic [7:0]  dipsw_a,
  input  logic [7:0]  dipsw_b,
  output logic        video_en,
  output logic        flip,
  output logic        snd_mute,
  output logic [1:0]  coin_cnt,
  output logic        wdog_rst
);
  localparam int WW = (WDOG_FRAMES > 1) ? $clog2(WDOG_FRAMES) : 1;
  localparam logic [WW-1:0] WLIM_M1 = WW'(WDOG_FRAMES - 1);

  logic          wr_q, wr_d, vint_q, vint_d, wdog_q, wdog_d;
  logic [7:0]    latch_q, latch_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [4:0]    addr;
  logic          wr_stb, wr_edge, vint_rise, kick;
  logic [7:0]    adc_res;
  logic          unused_bits;

  assign addr      = bus.cpu_addr[5:1];
  assign wr_stb    = bus.io_cs & ~bus.RnW & ~bus.LDSWn;
  // Held strobes are accepted once: only the first cycle counts.
  assign wr_edge   = wr_stb & ~wr_q;
  assign vint_rise = vint & ~vint_q;
  assign kick      = wr_edge && (addr == REG_WDOG);
  assign unused_bits = &{1'b0, joyana1[15:8], bus.cpu_addr[12:6]};

  jtoutrun_adc #(.ADC_CYCLES(ADC_CYCLES)) u_adc (
    .clk   (clk),
    .rst_n (rst_n),
    .start (wr_edge && (addr == REG_ADC)),
    .ch    (bus.cpu_dout[1:0]),
    .steer (joyana1[7:0]),
    .gas   (joyana1b[7:0]),
    .brake (joyana1b[15:8]),
    .res   (adc_res)
  );

  always_comb begin
    wr_d    = wr_stb;
    vint_d  = vint;
    latch_d = latch_q;
    wcnt_d  = wcnt_q;
    wdog_d  = 1'b0;
    if (wr_edge && (addr == REG_LATCH)) latch_d = bus.cpu_dout;
    if (WDOG_FRAMES != 0) begin
      if (kick) begin
        wcnt_d = '0;                 // kick beats a coincident frame edge
      end else if (vint_rise) begin
        if (wcnt_q == WLIM_M1) begin
          wcnt_d = '0;
          wdog_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      vint_q  <= 1'b0;
      wdog_q  <= 1'b0;
      latch_q <= 8'h00;
      wcnt_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      vint_q  <= vint_d;
      wdog_q  <= wdog_d;
      latch_q <= latch_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    case (addr)
      REG_SYS:   bus.cab_dout = {1'b1, coin_input, start_button[0], 1'b1, service, dip_test, 1'b1};
      REG_JOY:   bus.cab_dout = joystick1;
      REG_DIPA:  bus.cab_dout = dipsw_a;
      REG_DIPB:  bus.cab_dout = dipsw_b;
      REG_LATCH: bus.cab_dout = latch_q;
      REG_ADC:   bus.cab_dout = adc_res;
      default:   bus.cab_dout = 8'hFF;
    endcase
  end

  assign flip     = latch_q[LB_FLIP];
  assign snd_mute = latch_q[LB_MUTE];
  assign coin_cnt = latch_q[LB_COIN1:LB_COIN0];
  assign video_en = latch_q[LB_VIDEO];
  assign wdog_rst = wdog_q;
endmodule

// File: tb/tb_jtoutrun_cab.sv
module tb_jtoutrun_cab;
  localparam int ADC_CYCLES  = 256;
  localparam int WDOG_FRAMES = 64;

  logic        clk = 1'b0, rst_n = 1'b0, vint = 1'b0;
  logic [7:0]  joystick1 = 8'hFF, dipsw_a = 8'h00, dipsw_b = 8'h00;
  logic [15:0] joyana1 = 16'h0, joyana1b = 16'h0;
  logic [1:0]  start_button = 2'b11, coin_input = 2'b11, coin_cnt;
  logic        service = 1'b1, dip_test = 1'b1;
  logic        video_en, flip, snd_mute, wdog_rst;

  jtoutrun_cab_if bus();

  jtoutrun_cab #(.ADC_CYCLES(ADC_CYCLES), .WDOG_FRAMES(WDOG_FRAMES)) dut (
    .clk(clk), .rst_n(rst_n), .vint(vint), .bus(bus),
    .joystick1(joystick1), .joyana1(joyana1), .joyana1b(joyana1b),
    .start_button(start_button), .coin_input(coin_input), .service(service),
    .dip_test(dip_test), .dipsw_a(dipsw_a), .dipsw_b(dipsw_b),
    .video_en(video_en), .flip(flip), .snd_mute(snd_mute),
    .coin_cnt(coin_cnt), .wdog_rst(wdog_rst)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0, wd_seen = 0;

  // Behavioural model: conversions are "due" a fixed number of clocks after
  // their start; the watchdog counts frames since the last kick.
  logic [7:0] m_latch, m_res, m_pval;
  logic       m_pend, m_wrp, m_vp, m_wdog;
  int         m_due, m_cyc, m_frames;

  function automatic logic [7:0] m_conv(input logic [1:0] ch, input logic [7:0] st, ga, br);
    int v;
    case (ch)
      2'd0: return 8'(int'($signed(st)) + 128);
      2'd1, 2'd2: begin
        v = (ch == 2'd1) ? int'($signed(ga)) : int'($signed(br));
        if (v < 0) return 8'h00;
        v = 2 * v;
        return (v > 255) ? 8'hFF : 8'(v);
      end
      default: return 8'h80;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input logic [4:0] a);
    case (a)
      5'h00: return {1'b1, coin_input, start_button[0], 1'b1, service, dip_test, 1'b1};
      5'h01: return joystick1;
      5'h02: return dipsw_a;
      5'h03: return dipsw_b;
      5'h04: return m_latch;
      5'h18: return m_res;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic m_reset();
    m_latch = 8'h00; m_res = 8'h00; m_pval = 8'h00; m_pend = 1'b0;
    m_wrp = 1'b0; m_vp = 1'b0; m_wdog = 1'b0; m_due = 0; m_frames = 0;
  endtask

  task automatic m_step();
    logic wr, acc, rise;
    logic [4:0] a;
    m_cyc++;
    wr = bus.io_cs & ~bus.RnW & ~bus.LDSWn;
    acc = wr & ~m_wrp;
    m_wrp = wr;
    a = bus.cpu_addr[5:1];
    rise = vint & ~m_vp;
    m_vp = vint;
    m_wdog = 1'b0;
    if (acc && a == 5'h18) begin
      m_pend = 1'b1; m_due = m_cyc + ADC_CYCLES;
      m_pval = m_conv(bus.cpu_dout[1:0], joyana1[7:0], joyana1b[7:0], joyana1b[15:8]);
    end else if (m_pend && m_cyc == m_due) begin
      m_res = m_pval; m_pend = 1'b0;
    end
    if (acc && a == 5'h04) m_latch = bus.cpu_dout;
    if (acc && a == 5'h1F) m_frames = 0;
    else if (rise) begin
      m_frames++;
      if (m_frames == WDOG_FRAMES) begin m_frames = 0; m_wdog = 1'b1; end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1: check outputs against the model, then clock once.
  task automatic cycle();
    #1;
    chk("cab_dout", 32'(bus.cab_dout), 32'(m_read(bus.cpu_addr[5:1])));
    chk("outputs", 32'({video_en, flip, snd_mute, coin_cnt, wdog_rst}),
        32'({m_latch[5], m_latch[0], m_latch[1], m_latch[3:2], m_wdog}));
    if (wdog_rst) wd_seen++;
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [7:0] d, input int hold);
    bus.io_cs = 1'b1; bus.RnW = 1'b0; bus.LDSWn = 1'b0;
    bus.cpu_addr = {7'd0, a}; bus.cpu_dout = d;
    for (int i = 0; i < hold; i++) cycle();
    bus.io_cs = 1'b0; bus.RnW = 1'b1; bus.LDSWn = 1'b1;
  endtask

  task automatic vpulse();
    vint = 1'b1; cycle(); cycle();
    vint = 1'b0; cycle(); cycle();
  endtask

  typedef struct { logic [4:0] addr; logic [7:0] exp; } rd_vec_t;
  rd_vec_t tbl [9];
  logic [4:0] pool [9];

  initial begin
    int bad, hold, r;
    logic [4:0] a;
    tbl[0] = '{5'h00, 8'hDB}; tbl[1] = '{5'h01, 8'hA5}; tbl[2] = '{5'h02, 8'h5A};
    tbl[3] = '{5'h03, 8'hC3}; tbl[4] = '{5'h04, 8'h00}; tbl[5] = '{5'h18, 8'h00};
    tbl[6] = '{5'h05, 8'hFF}; tbl[7] = '{5'h1F, 8'hFF}; tbl[8] = '{5'h10, 8'hFF};
    pool = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h18, 5'h1F, 5'h05, 5'h10};
    bus.io_cs = 1'b0; bus.RnW = 1'b1; bus.LDSWn = 1'b1; bus.cpu_addr = '0; bus.cpu_dout = 8'h00;
    m_cyc = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;

    // Reset state and read map
    chk("rst_outputs", 32'({video_en, flip, snd_mute, coin_cnt, wdog_rst}), 32'd0);
    joystick1 = 8'hA5; dipsw_a = 8'h5A; dipsw_b = 8'hC3;
    coin_input = 2'b10; start_button = 2'b01; service = 1'b0; dip_test = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.cpu_addr = {7'd0, tbl[i].addr};
      cycle();
      chk("read_map", 32'(bus.cab_dout), 32'(tbl[i].exp));
    end

    // Latch write held 5 cycles, data changes mid-hold: only first accepted
    bus.io_cs = 1'b1; bus.RnW = 1'b0; bus.LDSWn = 1'b0;
    bus.cpu_addr = 12'h004; bus.cpu_dout = 8'h21;
    cycle();
    bus.cpu_dout = 8'h33;
    idle(4);
    bus.io_cs = 1'b0; bus.RnW = 1'b1; bus.LDSWn = 1'b1;
    cycle();
    chk("latch_flags", 32'({flip, video_en, snd_mute}), 32'(3'b110));
    chk("latch_readback", 32'(bus.cab_dout), 32'h21);

    // ADC steering conversion latency
    joyana1 = 16'h00C0;
    bus_wr(5'h18, 8'h00, 1);
    idle(255);
    chk("adc_busy_old", 32'(bus.cab_dout), 32'h00);
    cycle();
    chk("adc_steer", 32'(bus.cab_dout), 32'h40);
    joyana1b = 16'h00F0;
    bus_wr(5'h18, 8'h01, 1); idle(256);
    chk("adc_gas_neg", 32'(bus.cab_dout), 32'h00);
    joyana1b = 16'h007F;
    bus_wr(5'h18, 8'h01, 1); idle(256);
    chk("adc_gas_max", 32'(bus.cab_dout), 32'hFE);

    // Restart while BUSY: first result must never appear
    joyana1 = 16'h0010;
    bus_wr(5'h18, 8'h00, 1);
    idle(99);
    joyana1b = 16'h2000;
    bus_wr(5'h18, 8'h02, 1);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      cycle();
      if (bus.cab_dout !== 8'hFE) bad++;
    end
    chk("restart_hold", 32'(bad), 32'd0);
    cycle();
    chk("restart_res", 32'(bus.cab_dout), 32'h40);

    // Async reset mid-conversion with latch set
    bus_wr(5'h04, 8'h3F, 1);
    bus_wr(5'h18, 8'h00, 1);
    idle(50);
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", 32'({video_en, flip, snd_mute, coin_cnt, wdog_rst}), 32'd0);
    chk("arst_adc", 32'(bus.cab_dout), 32'h00);
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(300);
    chk("arst_no_result", 32'(bus.cab_dout), 32'h00);

    // Watchdog: 64 frames without a kick
    bus_wr(5'h1F, 8'h00, 1);
    wd_seen = 0;
    repeat (63) vpulse();
    chk("wdog_63", 32'(wd_seen), 32'd0);
    vpulse();
    chk("wdog_64", 32'(wd_seen), 32'd1);
    // Kick coincident with 63rd edge
    wd_seen = 0;
    repeat (62) vpulse();
    vint = 1'b1;
    bus_wr(5'h1F, 8'h00, 1);
    cycle(); vint = 1'b0; cycle(); cycle();
    repeat (63) vpulse();
    chk("wdog_kick_63", 32'(wd_seen), 32'd0);
    vpulse();
    chk("wdog_kick_64", 32'(wd_seen), 32'd1);

    // Randomized traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      joystick1 = 8'($urandom); dipsw_a = 8'($urandom); dipsw_b = 8'($urandom);
      joyana1 = 16'($urandom); joyana1b = 16'($urandom);
      coin_input = 2'($urandom); start_button = 2'($urandom);
      service = 1'($urandom); dip_test = 1'($urandom);
      if ($urandom_range(0, 7) == 0) vint = ~vint;
      if (hold > 0) hold--;
      else begin
        r = $urandom_range(0, 999);
        bus.io_cs = 1'b0; bus.RnW = 1'b1; bus.LDSWn = 1'b1;
        bus.cpu_dout = 8'($urandom);
        a = pool[$urandom_range(0, 8)];
        if (r < 40) begin
          bus.io_cs = 1'b1; bus.RnW = 1'b0; bus.LDSWn = 1'b0;
          hold = $urandom_range(0, 2);
          if (r < 25) a = 5'h04;
          else if (r < 27) a = 5'h18;
          else if (r < 28) a = 5'h1F;
          else a = 5'($urandom_range(5, 23));
        end else if (r < 45) begin
          bus.io_cs = 1'b1; bus.RnW = 1'b0; a = 5'h04;
        end else if (r < 600) begin
          bus.io_cs = 1'b1;
        end
        bus.cpu_addr = {7'd0, a};
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
